uart_param: RTL and testbench
=============================

UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame, legal 5..9.
REQ-002 Parameter BAUD_W, default 13: width of the baud divisor.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 RX  input  1  serial receive line, idle high, asynchronous to clk.
REQ-006 TX  output  1  serial transmit line, idle high.
REQ-007 trmt  input  1  single-cycle pulse that starts transmission of tx_data.
REQ-008 tx_data  input  DATA_W  byte to transmit, captured on trmt.
REQ-009 tx_done  output  1  high after a frame completes; held until the next accepted trmt.
REQ-010 tx_busy  output  1  high from the accepted trmt to the end of the last stop bit.
REQ-011 rx_data  output  DATA_W  last received word, LSB first on line.
REQ-012 rx_rdy  output  1  a received word is valid.
REQ-013 clr_rx_rdy  input  1  clears rx_rdy.
REQ-014 rx_err  output  2  {parity_err, frame_err} of the last received word, valid with rx_rdy.
REQ-015 baud_div  input  BAUD_W  clocks per bit.
REQ-016 par_en, par_odd, stop2  input  1 each  parity enable, odd-parity select, two stop bits.

Function
REQ-017 The bit period SHALL be max(baud_div,16) clocks; values below 16 SHALL be treated as 16.
REQ-018 The TX and RX sections SHALL latch baud_div, par_en, par_odd and stop2 at frame start; changes mid-frame SHALL NOT affect the frame in progress.
REQ-019 The TX FSM SHALL be IDLE->START->DATA(DATA_W bits, LSB first)->PARITY (only if par_en)->STOP(1 or 2 bits)->IDLE.
REQ-020 On trmt in IDLE, TX SHALL drive low on the next clock; tx_busy SHALL rise and tx_done SHALL fall in that same clock.
REQ-021 trmt while tx_busy SHALL be ignored with no effect on the frame or tx_data capture.
REQ-022 Parity bit SHALL be XOR of data bits when par_odd=0, and its inverse when par_odd=1.
REQ-023 RX SHALL pass through a two-flop synchroniser, with the first flop reset to 1; all RX decisions SHALL use the synchronised signal.
REQ-024 The RX FSM SHALL be IDLE->START->DATA->PARITY (if par_en)->STOP->IDLE; a falling edge in IDLE SHALL enter START.
REQ-025 RX SHALL sample each bit at count floor(period/2) after its nominal start; a high sample in START SHALL return to IDLE with no flags changed.
REQ-026 At the first stop-bit sample, rx_data, rx_err and rx_rdy=1 SHALL update together; frame_err=1 if that sample is 0; parity_err=1 on mismatch.
REQ-027 Only the first stop bit SHALL be checked by RX; stop2 affects TX only.
REQ-028 rx_rdy SHALL clear on clr_rx_rdy or on detection of a new start edge; if a clear and a set coincide, set SHALL win.
REQ-029 The receiver SHALL return to IDLE after the stop sample, so back-to-back frames are received without loss.
REQ-030 For DATA_W<8 the unused upper bits of rx_data SHALL NOT exist; the port width is DATA_W.

Reset
REQ-031 While rst is high: TX=1, tx_busy=0, tx_done=0, rx_rdy=0, rx_data=0, rx_err=0, both FSMs in IDLE, and all counters 0.
REQ-032 rst asserted mid-frame SHALL abort both frames immediately; the first trmt after deassertion SHALL start a clean frame.

Configuration
REQ-033 Macro UART_PARAM_PARITY_EN: when defined, par_en and par_odd SHALL behave as specified and the PARITY states SHALL exist.
REQ-034 Without UART_PARAM_PARITY_EN: par_en and par_odd SHALL be ignored, no PARITY state SHALL exist, and parity_err SHALL be tied to 0.

Verification
REQ-035 baud_div=16, tx_data=8'hA5 with TX looped to RX -> rx_data=8'hA5, rx_rdy=1, rx_err=0; frame is 160 clocks.
REQ-036 par_en=1, par_odd=1, stop2=1, tx_data=8'h03 -> parity bit 1 on the line, frame is 192 clocks, rx_err=0.
REQ-037 Injected RX frame 8'h55 with the stop bit forced low -> rx_rdy=1, frame_err=1; a following good 8'h0F frame gives rx_err=0.
REQ-038 A 3-clock low glitch on RX at baud_div=32 -> no rx_rdy, RX FSM back in IDLE.
REQ-039 Second trmt while busy, plus baud_div changed mid-frame -> the first frame is unaltered and the second trmt is ignored.
REQ-040 rst pulsed at data bit 4 of TX and RX -> TX=1, rx_rdy=0 immediately; the next trmt of 8'h3C is received correctly.

Source files
------------

// File: rtl/uart_param.sv
// Parameterised UART transceiver: 5..9 data bits, 1/2 stop bits, clamped baud divisor.
// Optional parity support is compiled in with `define UART_PARAM_PARITY_EN.
module uart_param #(
    parameter int DATA_W = 8,
    parameter int BAUD_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX,
    output logic              TX,
    input  logic              trmt,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_done,
    output logic              tx_busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_rdy,
    input  logic              clr_rx_rdy,
    output logic [1:0]        rx_err,
    input  logic [BAUD_W-1:0] baud_div,
    input  logic              par_en,
    input  logic              par_odd,
    input  logic              stop2
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] MIN_DIV = BAUD_W'(16);

`ifdef UART_PARAM_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
    logic unused_par;
    assign unused_par = par_en ^ par_odd;
`endif

    function automatic logic [BAUD_W-1:0] clamp_div(input logic [BAUD_W-1:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

`ifdef UART_PARAM_PARITY_EN
    function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction
`endif

    // Transmitter
    state_t            tx_state, tx_next;
    logic [BAUD_W-1:0] tx_period, tx_clk;
    logic [CNT_W-1:0]  tx_bit;
    logic [DATA_W-1:0] tx_shift;
    logic              tx_stop2, tx_second_stop, tx_bit_end;
`ifdef UART_PARAM_PARITY_EN
    logic              tx_use_par, tx_par_bit;
`endif

    assign tx_bit_end = (tx_clk == tx_period - BAUD_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= S_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (trmt) tx_next = S_START;
            S_START: if (tx_bit_end) tx_next = S_DATA;
`ifdef UART_PARAM_PARITY_EN
            S_DATA:  if (tx_bit_end && tx_bit == CNT_W'(DATA_W - 1))
                         tx_next = tx_use_par ? S_PAR : S_STOP;
            S_PAR:   if (tx_bit_end) tx_next = S_STOP;
`else
            S_DATA:  if (tx_bit_end && tx_bit == CNT_W'(DATA_W - 1)) tx_next = S_STOP;
`endif
            S_STOP:  if (tx_bit_end && (!tx_stop2 || tx_second_stop)) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        TX      = 1'b1;
        tx_busy = (tx_state != S_IDLE);
        case (tx_state)
            S_START: TX = 1'b0;
            S_DATA:  TX = tx_shift[0];
`ifdef UART_PARAM_PARITY_EN
            S_PAR:   TX = tx_par_bit;
`endif
            default: TX = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_clk         <= '0;
            tx_bit         <= '0;
            tx_period      <= '0;
            tx_shift       <= '0;
            tx_stop2       <= 1'b0;
            tx_second_stop <= 1'b0;
            tx_done        <= 1'b0;
`ifdef UART_PARAM_PARITY_EN
            tx_use_par     <= 1'b0;
            tx_par_bit     <= 1'b0;
`endif
        end else if (tx_state == S_IDLE) begin
            tx_clk         <= '0;
            tx_bit         <= '0;
            tx_second_stop <= 1'b0;
            if (trmt) begin
                tx_shift  <= tx_data;
                tx_period <= clamp_div(baud_div);
                tx_stop2  <= stop2;
                tx_done   <= 1'b0;
`ifdef UART_PARAM_PARITY_EN
                tx_use_par <= par_en;
                tx_par_bit <= parity_of(tx_data, par_odd);
`endif
            end
        end else if (tx_bit_end) begin
            tx_clk <= '0;
            if (tx_state == S_DATA) begin
                tx_shift <= tx_shift >> 1;
                tx_bit   <= tx_bit + CNT_W'(1);
            end
            if (tx_state == S_STOP) begin
                tx_second_stop <= 1'b1;
                if (tx_next == S_IDLE) tx_done <= 1'b1;
            end
        end else begin
            tx_clk <= tx_clk + BAUD_W'(1);
        end
    end

    // Receiver: two-flop synchroniser plus one history flop for edge detection
    logic rx_s1, rx_s2, rx_s3, rx_fall;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end
    assign rx_fall = rx_s3 & ~rx_s2;

    state_t            rx_state, rx_next;
    logic [BAUD_W-1:0] rx_period, rx_clk;
    logic [CNT_W-1:0]  rx_bit;
    logic [DATA_W-1:0] rx_shift;
    logic              rx_mid, rx_bit_end, rx_set, rx_start_edge, par_err;
`ifdef UART_PARAM_PARITY_EN
    logic              rx_use_par, rx_par_odd, rx_par_s;
    assign par_err = rx_use_par && (parity_of(rx_shift, rx_par_odd) != rx_par_s);
`else
    assign par_err = 1'b0;
`endif

    assign rx_mid     = (rx_clk == (rx_period >> 1));
    assign rx_bit_end = (rx_clk == rx_period - BAUD_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= S_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            S_START: if (rx_mid && rx_s2) rx_next = S_IDLE;
                     else if (rx_bit_end) rx_next = S_DATA;
`ifdef UART_PARAM_PARITY_EN
            S_DATA:  if (rx_bit_end && rx_bit == CNT_W'(DATA_W))
                         rx_next = rx_use_par ? S_PAR : S_STOP;
            S_PAR:   if (rx_bit_end) rx_next = S_STOP;
`else
            S_DATA:  if (rx_bit_end && rx_bit == CNT_W'(DATA_W)) rx_next = S_STOP;
`endif
            S_STOP:  if (rx_mid) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_set        = (rx_state == S_STOP) && rx_mid;
        rx_start_edge = (rx_state == S_IDLE) && rx_fall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_clk     <= '0;
            rx_bit     <= '0;
            rx_period  <= '0;
            rx_shift   <= '0;
            rx_data    <= '0;
            rx_err     <= '0;
`ifdef UART_PARAM_PARITY_EN
            rx_use_par <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_s   <= 1'b0;
`endif
        end else if (rx_state == S_IDLE) begin
            rx_clk <= '0;
            rx_bit <= '0;
            if (rx_fall) begin
                rx_period <= clamp_div(baud_div);
`ifdef UART_PARAM_PARITY_EN
                rx_use_par <= par_en;
                rx_par_odd <= par_odd;
`endif
            end
        end else begin
            rx_clk <= rx_bit_end ? '0 : rx_clk + BAUD_W'(1);
            if (rx_mid) begin
                case (rx_state)
                    S_DATA: begin
                        rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
                        rx_bit   <= rx_bit + CNT_W'(1);
                    end
`ifdef UART_PARAM_PARITY_EN
                    S_PAR:  rx_par_s <= rx_s2;
`endif
                    S_STOP: begin
                        rx_data <= rx_shift;
                        rx_err  <= {par_err, ~rx_s2};
                    end
                    default: ;
                endcase
            end
        end
    end

    // A completed frame outranks a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             rx_rdy <= 1'b0;
        else if (rx_set)                     rx_rdy <= 1'b1;
        else if (clr_rx_rdy || rx_start_edge) rx_rdy <= 1'b0;
    end
endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: loopback, injected RX frames, glitches, busy and reset.
module tb_uart_param;
    localparam int DATA_W = 8;
    localparam int BAUD_W = 13;
`ifdef UART_PARAM_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, loop, rx_drv, rx_line, TX;
    logic              trmt, tx_done, tx_busy, rx_rdy, clr_rx_rdy;
    logic              par_en, par_odd, stop2;
    logic [DATA_W-1:0] tx_data, rx_data;
    logic [1:0]        rx_err;
    logic [BAUD_W-1:0] baud_div;
    int                checks = 0;
    int                passes = 0;
    bit                frame_q[$];

    assign rx_line = loop ? TX : rx_drv;
    always #5 clk = ~clk;

    uart_param #(.DATA_W(DATA_W), .BAUD_W(BAUD_W)) dut (
        .clk(clk), .rst(rst), .RX(rx_line), .TX(TX), .trmt(trmt), .tx_data(tx_data),
        .tx_done(tx_done), .tx_busy(tx_busy), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .clr_rx_rdy(clr_rx_rdy), .rx_err(rx_err), .baud_div(baud_div),
        .par_en(par_en), .par_odd(par_odd), .stop2(stop2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the line image of one frame as a list of bit values
    function automatic int eff_period(input int d);
        return (d < 16) ? 16 : d;
    endfunction

    function automatic void build_frame(input logic [DATA_W-1:0] d, input bit pe, input bit po,
                                        input bit s2);
        frame_q.delete();
        frame_q.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) frame_q.push_back(d[i]);
        if (PAR_BUILT && pe) frame_q.push_back((^d) ^ po);
        frame_q.push_back(1'b1);
        if (s2) frame_q.push_back(1'b1);
    endfunction

    task automatic send_frame(input logic [DATA_W-1:0] d, input int div, input bit pe,
                              input bit po, input bit s2, input bit disturb, input string tag);
        int p, nb, busy_cnt, first_bad;
        logic rdy_mid;
        build_frame(d, pe, po, s2);
        p = eff_period(div);
        nb = frame_q.size();
        tx_data = d; baud_div = div[BAUD_W-1:0]; par_en = pe; par_odd = po; stop2 = s2;
        trmt = 1'b1;
        tick();
        trmt = 1'b0;
        tx_data = DATA_W'($urandom);
        checks++;
        if (TX !== 1'b0 || tx_busy !== 1'b1 || tx_done !== 1'b0)
            $display("FAIL %s_start: TX/busy/done=%b%b%b want 010", tag, TX, tx_busy, tx_done);
        else passes++;
        busy_cnt = 1; first_bad = -1; rdy_mid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < p; c++) begin
                if (c == p / 2 && TX !== frame_q[i] && first_bad < 0) first_bad = i;
                if (i == 1 && c == p / 2) rdy_mid = rx_rdy;
                if (disturb && i == 3 && c == p / 2) begin
                    trmt = 1'b1; tx_data = ~d; baud_div = BAUD_W'(div + 37);
                    par_en = ~pe; stop2 = ~s2;
                end
                tick();
                trmt = 1'b0;
                if (tx_busy) busy_cnt++;
            end
        end
        checks++;
        if (first_bad >= 0) $display("FAIL %s_line: bit %0d wrong, data %h", tag, first_bad, d);
        else passes++;
        checks++;
        if (busy_cnt !== nb * p) $display("FAIL %s_len: busy %0d clocks want %0d", tag, busy_cnt, nb * p);
        else passes++;
        checks++;
        if (tx_done !== 1'b1 || tx_busy !== 1'b0)
            $display("FAIL %s_end: done/busy=%b%b want 10", tag, tx_done, tx_busy);
        else passes++;
        if (loop) begin
            checks++;
            if (rdy_mid !== 1'b0) $display("FAIL %s_rdyclr: rx_rdy mid-frame %b want 0", tag, rdy_mid);
            else passes++;
            checks++;
            if (rx_rdy !== 1'b1 || rx_data !== d || rx_err !== 2'b00)
                $display("FAIL %s_rx: rdy=%b data=%h err=%b want 1 %h 00", tag, rx_rdy, rx_data, rx_err, d);
            else passes++;
        end
    endtask

    task automatic inject_frame(input logic [DATA_W-1:0] d, input int div, input bit stop_val,
                                input string tag);
        int p;
        build_frame(d, 1'b0, 1'b0, 1'b0);
        frame_q[frame_q.size() - 1] = stop_val;
        p = eff_period(div);
        baud_div = div[BAUD_W-1:0]; par_en = 1'b0;
        foreach (frame_q[i]) begin
            rx_drv = frame_q[i];
            repeat (p) tick();
        end
        rx_drv = 1'b1;
        repeat (p) tick();
        checks++;
        if (rx_rdy !== 1'b1 || rx_data !== d || rx_err !== {1'b0, ~stop_val})
            $display("FAIL %s: rdy=%b data=%h err=%b want 1 %h 0%b", tag, rx_rdy, rx_data, rx_err, d, ~stop_val);
        else passes++;
    endtask

    task automatic test_reset();
        checks++;
        if (TX !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || rx_rdy !== 1'b0 ||
            rx_data !== '0 || rx_err !== 2'b00)
            $display("FAIL reset: TX=%b busy=%b done=%b rdy=%b data=%h err=%b want 1 0 0 0 00 00",
                     TX, tx_busy, tx_done, rx_rdy, rx_data, rx_err);
        else passes++;
    endtask

    task automatic test_loopback();
        loop = 1'b1;
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b0, "loop_a5");
        send_frame(8'h03, 16, 1'b1, 1'b1, 1'b1, 1'b0, "par_03");
        send_frame(8'h5A, 4, 1'b0, 1'b0, 1'b0, 1'b0, "clamp");
    endtask

    task automatic test_frame_err();
        loop = 1'b0; rx_drv = 1'b1;
        repeat (4) tick();
        inject_frame(8'h55, 16, 1'b0, "ferr_55");
        inject_frame(8'h0F, 16, 1'b1, "good_0f");
        clr_rx_rdy = 1'b1;
        tick();
        clr_rx_rdy = 1'b0;
        checks++;
        if (rx_rdy !== 1'b0 || rx_data !== 8'h0F)
            $display("FAIL clr_rdy: rdy=%b data=%h want 0 0f", rx_rdy, rx_data);
        else passes++;
    endtask

    task automatic test_glitch();
        loop = 1'b0; baud_div = 32;
        rx_drv = 1'b0;
        repeat (3) tick();
        rx_drv = 1'b1;
        repeat (64) tick();
        checks++;
        if (rx_rdy !== 1'b0) $display("FAIL glitch: rx_rdy=%b want 0", rx_rdy);
        else passes++;
        inject_frame(DATA_W'($urandom), 32, 1'b1, "after_glitch");
    endtask

    task automatic test_busy_ignore();
        loop = 1'b1;
        send_frame(8'hC3, 20, 1'b0, 1'b0, 1'b0, 1'b1, "busy");
        repeat (5) tick();
        checks++;
        if (tx_busy !== 1'b0 || TX !== 1'b1) $display("FAIL busy_idle: busy=%b TX=%b want 0 1", tx_busy, TX);
        else passes++;
    endtask

    task automatic test_back_to_back();
        loop = 1'b1;
        send_frame(DATA_W'($urandom), 16, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_1");
        send_frame(DATA_W'($urandom), 16, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_2");
    endtask

    task automatic test_random();
        loop = 1'b1;
        for (int n = 0; n < 8; n++)
            send_frame(DATA_W'($urandom), int'($urandom_range(40, 0)), 1'($urandom),
                       1'($urandom), 1'($urandom), 1'b0, "rand");
    endtask

    task automatic test_reset_mid();
        loop = 1'b1;
        tx_data = 8'hFF; baud_div = 16; par_en = 1'b0; stop2 = 1'b0;
        trmt = 1'b1;
        tick();
        trmt = 1'b0;
        repeat (16 * 5 + 8) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (TX !== 1'b1 || tx_busy !== 1'b0 || rx_rdy !== 1'b0 || rx_data !== '0 || rx_err !== 2'b00)
            $display("FAIL rst_mid: TX=%b busy=%b rdy=%b data=%h err=%b want 1 0 0 00 00",
                     TX, tx_busy, rx_rdy, rx_data, rx_err);
        else passes++;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst");
    endtask

    initial begin
        rst = 1'b1; loop = 1'b1; rx_drv = 1'b1; trmt = 1'b0; clr_rx_rdy = 1'b0;
        tx_data = '0; baud_div = 16; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
        repeat (3) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_loopback();
        test_frame_err();
        test_glitch();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
